// File: rtl/gpr_file_mp.sv
// gpr_file_mp: parametrised multi-port general-purpose register file.
//
// NREAD combinational read ports, two write-back ports (port 1 wins on an
// address collision), optional same-cycle write-to-read bypass and a
// per-register pending-write (busy) scoreboard. Register 0 is hard zero.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   ra / rd / rbusy      packed read addresses, read data, busy flags per port
//   we0/wa0/wd0          write port 0 (ALU write-back)
//   we1/wa1/wd1          write port 1 (memory write-back), higher priority
//   mark_en/mark_addr    mark a destination register busy (decode)
//   busy_any             OR of all registered busy bits
module gpr_file_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic                    mark_en,
  input  logic [ADDR_W-1:0]       mark_addr,
  output logic                    busy_any
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;

  // Qualified write/mark strobes: address 0 and the reset cycle are dropped.
  logic wr0_ok, wr1_ok, mark_ok;
  assign wr0_ok  = !reset && we0 && (wa0 != '0);
  assign wr1_ok  = !reset && we1 && (wa1 != '0);
  assign mark_ok = !reset && mark_en && (mark_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 1; i < Depth; i++) begin
        if (wr1_ok && (wa1 == ADDR_W'(i))) begin
          regs_q[i] <= wd1;
        end else if (wr0_ok && (wa0 == ADDR_W'(i))) begin
          regs_q[i] <= wd0;
        end
      end
      busy_q <= busy_d;
    end
  end

  // Commits clear busy; a mark applied last so a younger producer wins a race.
  always_comb begin
    busy_d = busy_q;
    if (wr0_ok) busy_d[wa0] = 1'b0;
    if (wr1_ok) busy_d[wa1] = 1'b0;
    if (mark_ok) busy_d[mark_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic              hit0, hit1;
    rd    = '0;
    rbusy = '0;
    addr  = '0;
    hit0  = 1'b0;
    hit1  = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      addr = ra[k*ADDR_W +: ADDR_W];
      hit1 = BYPASS && wr1_ok && (wa1 == addr);
      hit0 = BYPASS && wr0_ok && (wa0 == addr);
      if (reset || (addr == '0)) begin
        // Outputs read as zero during the reset cycle and for r0.
        rd[k*DATA_W +: DATA_W] = '0;
        rbusy[k]               = 1'b0;
      end else begin
        if (hit1) begin
          rd[k*DATA_W +: DATA_W] = wd1;
        end else if (hit0) begin
          rd[k*DATA_W +: DATA_W] = wd0;
        end else begin
          rd[k*DATA_W +: DATA_W] = regs_q[addr];
        end
        // A same-cycle commit retires the producer as seen by the reader.
        rbusy[k] = busy_q[addr] && !(hit0 || hit1);
      end
    end
  end

  assign busy_any = !reset && (|busy_q);

endmodule

// File: tb/tb_gpr_file_mp.sv
module tb_gpr_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instances A (BYPASS=1) and B (BYPASS=0) share stimulus.
  logic        reset = 1'b1;
  logic [9:0]  ra;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  rb_a, rb_b;
  logic        ba_a, ba_b;
  logic        we0, we1, mark_en;
  logic [4:0]  wa0, wa1, mark_addr;
  logic [31:0] wd0, wd1;

  // Instance C: DATA_W=16, ADDR_W=3, NREAD=4, random sweep.
  logic        c_reset = 1'b1;
  logic [11:0] c_ra = '0;
  logic [63:0] c_rd;
  logic [3:0]  c_rb;
  logic        c_ba;
  logic        c_we0 = 1'b0, c_we1 = 1'b0, c_mark_en = 1'b0;
  logic [2:0]  c_wa0 = '0, c_wa1 = '0, c_mark_addr = '0;
  logic [15:0] c_wd0 = '0, c_wd1 = '0;

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1'b1)) u_a (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_a), .rbusy(rb_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .mark_en(mark_en), .mark_addr(mark_addr), .busy_any(ba_a)
  );

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rbusy(rb_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .mark_en(mark_en), .mark_addr(mark_addr), .busy_any(ba_b)
  );

  gpr_file_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .BYPASS(1'b1)) u_c (
    .clk(clk), .reset(c_reset), .ra(c_ra), .rd(c_rd), .rbusy(c_rb),
    .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0), .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1),
    .mark_en(c_mark_en), .mark_addr(c_mark_addr), .busy_any(c_ba)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        mk;
    logic [4:0]  ma;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  arb;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [1:0]  brb;
    logic        bany;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic w0, input logic [4:0] a_w0,
                     input logic [31:0] d0, input logic w1, input logic [4:0] a_w1,
                     input logic [31:0] d1, input logic mk, input logic [4:0] ma,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic [31:0] ea0, input logic [31:0] ea1, input logic [1:0] earb,
                     input logic [31:0] eb0, input logic [31:0] eb1, input logic [1:0] ebrb,
                     input logic bany);
    vec_t v;
    v.rst = rst; v.we0 = w0; v.wa0 = a_w0; v.wd0 = d0; v.we1 = w1; v.wa1 = a_w1;
    v.wd1 = d1; v.mk = mk; v.ma = ma; v.ra0 = r0; v.ra1 = r1;
    v.a0 = ea0; v.a1 = ea1; v.arb = earb; v.b0 = eb0; v.b1 = eb1; v.brb = ebrb;
    v.bany = bany;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic w0, input logic [4:0] a_w0,
                       input logic [31:0] d0, input logic [4:0] r0, input logic [4:0] r1);
    reset = rst; we0 = w0; wa0 = a_w0; wd0 = d0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; mark_en = 1'b0; mark_addr = '0;
    ra = {r1, r0};
  endtask

  // C reference model
  logic [15:0] m_mem [8];
  logic [7:0]  m_busy;

  initial begin
    logic [63:0] e_rd;
    logic [3:0]  e_rb;
    logic [2:0]  a;
    logic        h0, h1;

    //  rst we0 wa0 wd0           we1 wa1 wd1           mk ma ra0 ra1
    //  | A rd0        A rd1        Arb | B rd0        B rd1        Brb | bany
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 2,
        32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    add(0, 1, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0,
        32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,
        32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    add(0, 1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 5, 6,
        32'h22222222, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    add(0, 1, 5, 32'h11111111, 1, 6, 32'h22222222, 0, 0, 5, 6,
        32'h11111111, 32'h22222222, 2'b00, 32'h22222222, 32'h0, 2'b00, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 5, 6,
        32'h11111111, 32'h22222222, 2'b00, 32'h11111111, 32'h22222222, 2'b00, 0);
    add(0, 1, 7, 32'hA5A5A5A5, 0, 0, 32'h0,        0, 0, 7, 5,
        32'hA5A5A5A5, 32'h11111111, 2'b00, 32'h0, 32'h11111111, 2'b00, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 7, 0,
        32'hA5A5A5A5, 32'h0, 2'b00, 32'hA5A5A5A5, 32'h0, 2'b00, 0);
    // scoreboard: mark r9 at t, commit at t+3
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 9, 0,
        32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 9, 9,
        32'h0, 32'h0, 2'b11, 32'h0, 32'h0, 2'b11, 1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 9, 0,
        32'h0, 32'h0, 2'b01, 32'h0, 32'h0, 2'b01, 1);
    add(0, 1, 9, 32'h12345678, 0, 0, 32'h0,        0, 0, 9, 0,
        32'h12345678, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01, 1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 9, 0,
        32'h12345678, 32'h0, 2'b00, 32'h12345678, 32'h0, 2'b00, 0);
    // mark/clear race on r3
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 3, 0,
        32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    add(0, 0, 0, 32'h0,        1, 3, 32'hCAFEF00D, 1, 3, 3, 0,
        32'hCAFEF00D, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01, 1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 0,
        32'hCAFEF00D, 32'h0, 2'b01, 32'hCAFEF00D, 32'h0, 2'b01, 1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 3,
        32'h0, 32'hCAFEF00D, 2'b10, 32'h0, 32'hCAFEF00D, 2'b10, 1);
    // mid-operation reset with a write and a mark that must be ignored
    add(1, 1, 3, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 4, 3, 5,
        32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 5,
        32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 4, 7,
        32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      reset = vecs[i].rst;
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      mark_en = vecs[i].mk; mark_addr = vecs[i].ma;
      ra = {vecs[i].ra1, vecs[i].ra0};
      @(negedge clk);
      chk($sformatf("v%0d A.rd",   i), {rd_a[63:32], rd_a[31:0]}, {vecs[i].a1, vecs[i].a0});
      chk($sformatf("v%0d A.rbusy", i), rb_a, vecs[i].arb);
      chk($sformatf("v%0d B.rd",   i), {rd_b[63:32], rd_b[31:0]}, {vecs[i].b1, vecs[i].b0});
      chk($sformatf("v%0d B.rbusy", i), rb_b, vecs[i].brb);
      chk($sformatf("v%0d busy_any", i), {ba_a, ba_b}, {vecs[i].bany, vecs[i].bany});
    end

    // Fill r1..r31, spot-check, then reset and confirm every register reads 0.
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
    @(negedge clk);
    chk("fill A.rd", rd_a, {32'h1F1F1F1F, 32'h11111111});
    chk("fill B.rd", rd_b, {32'h1F1F1F1F, 32'h11111111});
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
    @(negedge clk);
    chk("in-reset rd", {rd_a, rd_b}, 128'h0);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      @(negedge clk);
      chk($sformatf("post-reset r%0d", i), {rd_a, rd_b, rb_a, rb_b}, '0);
    end

    // Random sweep on the narrow, 4-port instance.
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_busy = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk); #1;
      c_reset     = (cyc == 0) || ($urandom_range(0, 299) == 0);
      c_we0       = 1'($urandom_range(0, 1));
      c_wa0       = 3'($urandom_range(0, 7));
      c_wd0       = 16'($urandom);
      c_we1       = 1'($urandom_range(0, 1));
      c_wa1       = ($urandom_range(0, 3) == 0) ? c_wa0 : 3'($urandom_range(0, 7));
      c_wd1       = 16'($urandom);
      c_mark_en   = ($urandom_range(0, 2) == 0);
      c_mark_addr = ($urandom_range(0, 3) == 0) ? c_wa1 : 3'($urandom_range(0, 7));
      c_ra        = 12'($urandom);
      @(negedge clk);
      e_rd = '0;
      e_rb = '0;
      for (int k = 0; k < 4; k++) begin
        a  = c_ra[k*3 +: 3];
        h1 = c_we1 && (c_wa1 == a);
        h0 = c_we0 && (c_wa0 == a);
        if (!c_reset && a != 3'd0) begin
          e_rd[k*16 +: 16] = h1 ? c_wd1 : (h0 ? c_wd0 : m_mem[a]);
          e_rb[k] = m_busy[a] && !(h0 || h1);
        end
      end
      chk($sformatf("sweep cyc%0d", cyc), {c_rd, c_rb, c_ba},
          {e_rd, e_rb, (!c_reset && (|m_busy))});
      if (c_reset) begin
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_busy = '0;
      end else begin
        if (c_we0 && c_wa0 != 3'd0) begin m_mem[c_wa0] = c_wd0; m_busy[c_wa0] = 1'b0; end
        if (c_we1 && c_wa1 != 3'd0) begin m_mem[c_wa1] = c_wd1; m_busy[c_wa1] = 1'b0; end
        if (c_mark_en && c_mark_addr != 3'd0) m_busy[c_mark_addr] = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_file_mp.md
# gpr_file_mp

Parametrised multi-port general-purpose register file for the MIPS core, the successor to the fixed 32x32 two-read/one-write GPR. It provides N combinational read ports, two write-back ports with a defined collision priority, optional write-to-read bypass, and a per-register pending-write scoreboard. It sits between decode (reads, busy checks, producer marking) and write-back (commits).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears every register and every busy bit
- ra  in  NREAD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd  out  NREAD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- rbusy  out  NREAD  1 = register addressed by port k has an outstanding producer
- we0 / wa0 / wd0  in  1 / ADDR_W / DATA_W  write port 0 (ALU write-back)
- we1 / wa1 / wd1  in  1 / ADDR_W / DATA_W  write port 1 (memory write-back), higher priority
- mark_en  in  1  decode has issued an instruction that will write mark_addr
- mark_addr  in  ADDR_W  destination register being marked busy
- busy_any  out  1  OR of all busy bits (drain indicator)

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus a busy bit per register.
- Register 0 is hard zero: reads always return 0 with rbusy=0; writes and marks to address 0 are discarded and never change state.
- Writes: on a rising edge with wrN=weN and waN!=0, reg[waN] <= wdN. If we0 and we1 both target the same non-zero address, wd1 is stored and wd0 is dropped. Different addresses both commit.
- Reads are combinational. For port k: if ra_k==0, rd_k=0. Else, if BYPASS=1 and we1 && wa1==ra_k, rd_k=wd1. Else, if BYPASS=1 and we0 && wa0==ra_k, rd_k=wd0. Else rd_k=reg[ra_k].
- Scoreboard: a valid write to address a clears busy[a] at the edge. mark_en with mark_addr!=0 sets busy[mark_addr] at the edge. If a mark and a write hit the same address in one cycle, set wins, because the new producer is younger.
- rbusy_k = busy[ra_k] & ~(BYPASS & a write to ra_k this cycle). With BYPASS=0 the raw busy bit is shown.
- busy_any = |busy (registered bits only, no bypass term).
- Reset: all registers = 0 and all busy = 0. In the reset cycle, writes and marks are ignored.

## Timing
- Write latency: 1 cycle to storage. Read-after-write is visible in the same cycle with BYPASS=1 and in the next cycle with BYPASS=0.
- Mark latency: busy is visible on rbusy in the cycle after mark_en.
- Outputs during and after reset: rd=0 on all ports, rbusy=0, busy_any=0, until the first post-reset write or mark.
- Reset asserted mid-operation: pending busy bits are lost and data is cleared on that edge. Decode must re-mark after reset.
- No handshake back-pressure. Every write and mark presented is accepted in one cycle.
- Critical path: ra to rd through the 2-level bypass mux and the storage read mux. No registered outputs.

## Test plan
- Reset/zero: write 0xDEADBEEF to r0 via both ports, then read r0 on all ports -> rd=0, rbusy=0. Assert reset after filling r1..r31 -> every read returns 0 on the next cycle.
- Collision: we0=we1=1, wa0=wa1=5, wd0=0x11111111, wd1=0x22222222 -> r5 reads 0x22222222. Repeat with wa0=5, wa1=6 -> r5=0x11111111, r6=0x22222222.
- Bypass: BYPASS=1, we0 wa0=7 wd0=0xA5A5A5A5, ra0=7 in the same cycle -> rd0=0xA5A5A5A5 combinationally. BYPASS=0 instance -> old value in that cycle, new value the next cycle.
- Scoreboard: mark r9 at cycle t -> rbusy for r9 =1 at t+1 and busy_any=1. Write r9 at t+3 -> rbusy=0 during t+3 (BYPASS=1), busy bit clear at t+4, busy_any=0.
- Mark/clear race: r3 busy; same cycle mark_en r3 and we1 wa1=3 -> after the edge r3 holds the new data and busy[3]=1.
- Parameter sweep: DATA_W=16, ADDR_W=3, NREAD=4 -> random writes and reads against a reference model for 10k cycles with zero mismatches, including r0 and collision cases.
